// File: rtl/avr_sram_bridge_pkg.sv
// Shared definitions for the AVR-to-SRAM bridge: bus state encoding and
// default bus widths.
package avr_sram_bridge_pkg;

    localparam int DEF_ADDR_WIDTH = 21;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_READ        = 2'd1,
        ST_WRITE_SETUP = 2'd2,
        ST_WRITE       = 2'd3
    } bus_state_t;

endpackage

// File: rtl/avr_sram_bridge_addr_sreg.sv
// Serial-in address register: the AVR clocks the SRAM address in MSB first
// while shifting is enabled, and the value holds otherwise.
module avr_sram_bridge_addr_sreg
    import avr_sram_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic                  si,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [ADDR_WIDTH-1:0] sreg_q;
    logic [ADDR_WIDTH-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (shift_en) begin
            sreg_d = {sreg_q[ADDR_WIDTH-2:0], si};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign addr = sreg_q;

endmodule

// File: rtl/avr_sram_bridge_bus_fsm.sv
// Bus sequencer: decides read/write cycles, owns the data buffer and the
// tri-state enables for both data buses. Strobes are decoded from state only.
module avr_sram_bridge_bus_fsm
    import avr_sram_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sreg_en,
    input  logic                  rd_req_n,
    input  logic                  wr_req_n,
    input  logic [DATA_WIDTH-1:0] avr_din,
    input  logic [DATA_WIDTH-1:0] sram_din,
    output logic [DATA_WIDTH-1:0] data_buf,
    output logic                  avr_drive,
    output logic                  sram_drive,
    output logic                  ce_n,
    output logic                  oe_n,
    output logic                  we_n
);

    bus_state_t            state_q;
    bus_state_t            state_d;
    logic [DATA_WIDTH-1:0] data_buf_q;
    logic [DATA_WIDTH-1:0] data_buf_d;

    always_comb begin
        state_d    = state_q;
        data_buf_d = data_buf_q;
        avr_drive  = 1'b0;
        sram_drive = 1'b0;
        ce_n       = 1'b1;
        oe_n       = 1'b1;
        we_n       = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // A read request takes priority over a simultaneous write.
                if (sreg_en && !rd_req_n) begin
                    state_d = ST_READ;
                end else if (sreg_en && !wr_req_n) begin
                    state_d = ST_WRITE_SETUP;
                end
            end
            ST_READ: begin
                ce_n       = 1'b0;
                oe_n       = 1'b0;
                avr_drive  = 1'b1;
                data_buf_d = sram_din;
                if (rd_req_n) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE_SETUP: begin
                ce_n       = 1'b0;
                sram_drive = 1'b1;
                data_buf_d = avr_din;
                state_d    = wr_req_n ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: begin
                ce_n       = 1'b0;
                we_n       = 1'b0;
                sram_drive = 1'b1;
                // Keep sampling so data that settles late still lands in SRAM.
                data_buf_d = avr_din;
                if (wr_req_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Address shifting always aborts any bus cycle.
        if (!sreg_en) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            data_buf_q <= data_buf_d;
        end
    end

    assign data_buf = data_buf_q;

endmodule

// File: rtl/avr_sram_bridge.sv
// CPLD top: glues an AVR to an external byte-wide SRAM through a serially
// loaded address register and a registered bidirectional data buffer.
module avr_sram_bridge
    import avr_sram_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  avr_clk,
    input  logic                  avr_reset,
    input  logic                  avr_si,
    input  logic                  avr_sreg_en,
    input  logic                  avr_oe,
    input  logic                  avr_we,
    input  logic                  avr_ce,
    input  logic [2:0]            avr_ctrl,
    inout  wire  [DATA_WIDTH-1:0] avr_data,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    logic [DATA_WIDTH-1:0] data_buf;
    logic                  avr_drive;
    logic                  sram_drive;
    logic                  unused_inputs;

    assign unused_inputs = ^{avr_ce, avr_ctrl};

    avr_sram_bridge_addr_sreg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_sreg (
        .clk      (avr_clk),
        .rst_n    (avr_reset),
        .shift_en (~avr_sreg_en),
        .si       (avr_si),
        .addr     (sram_addr)
    );

    avr_sram_bridge_bus_fsm #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bus_fsm (
        .clk        (avr_clk),
        .rst_n      (avr_reset),
        .sreg_en    (avr_sreg_en),
        .rd_req_n   (avr_oe),
        .wr_req_n   (avr_we),
        .avr_din    (avr_data),
        .sram_din   (sram_data),
        .data_buf   (data_buf),
        .avr_drive  (avr_drive),
        .sram_drive (sram_drive),
        .ce_n       (sram_ce_n),
        .oe_n       (sram_oe_n),
        .we_n       (sram_we_n)
    );

    // The FSM never asserts both enables, so the buffer has one owner at a time.
    assign avr_data  = avr_drive  ? data_buf : {DATA_WIDTH{1'bz}};
    assign sram_data = sram_drive ? data_buf : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_avr_sram_bridge.sv
// Self-checking bench for avr_sram_bridge: directed vector table, hand-written
// reset sequences and randomized cycles against a behavioural model.
module tb_avr_sram_bridge;

    localparam int AW = 21;
    localparam int DW = 8;
    localparam logic [AW-1:0] AMASK = {AW{1'b1}};

    localparam int M_IDLE = 0;
    localparam int M_READ = 1;
    localparam int M_WSET = 2;
    localparam int M_WRT  = 3;

    logic          avr_clk = 1'b0;
    logic          avr_reset;
    logic          avr_si;
    logic          avr_sreg_en;
    logic          avr_oe;
    logic          avr_we;
    logic          avr_ce;
    logic [2:0]    avr_ctrl;
    wire  [DW-1:0] avr_data;
    wire  [DW-1:0] sram_data;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    logic [DW-1:0] tb_avr_val;
    logic [DW-1:0] tb_sram_val;

    int checks = 0;
    int errors = 0;

    always #5 avr_clk = ~avr_clk;

    // AVR drives its bus whenever the SRAM is not being read; the SRAM model
    // drives its bus only while its output enable is asserted.
    assign avr_data  = sram_oe_n  ? tb_avr_val  : {DW{1'bz}};
    assign sram_data = !sram_oe_n ? tb_sram_val : {DW{1'bz}};

    avr_sram_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .avr_clk     (avr_clk),
        .avr_reset   (avr_reset),
        .avr_si      (avr_si),
        .avr_sreg_en (avr_sreg_en),
        .avr_oe      (avr_oe),
        .avr_we      (avr_we),
        .avr_ce      (avr_ce),
        .avr_ctrl    (avr_ctrl),
        .avr_data    (avr_data),
        .sram_data   (sram_data),
        .sram_addr   (sram_addr),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    typedef struct {
        logic          sreg_en;
        logic          si;
        logic          oe;
        logic          we;
        logic [DW-1:0] avr_val;
        logic [DW-1:0] sram_val;
        logic [AW-1:0] addr;
        logic          ce_n;
        logic          oe_n;
        logic          we_n;
        logic          avr_drv;
        logic          sram_drv;
        logic [DW-1:0] data;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic sreg_en, si, oe, we,
                                input logic [DW-1:0] av, sv,
                                input logic [AW-1:0] addr,
                                input logic ce_n, oe_n, we_n, ad, sd,
                                input logic [DW-1:0] data);
        vec_t v;
        v.sreg_en = sreg_en; v.si = si; v.oe = oe; v.we = we;
        v.avr_val = av; v.sram_val = sv; v.addr = addr;
        v.ce_n = ce_n; v.oe_n = oe_n; v.we_n = we_n;
        v.avr_drv = ad; v.sram_drv = sd; v.data = data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [AW-1:0] addr,
                             input logic ce_n, oe_n, we_n, ad, sd,
                             input logic [DW-1:0] data);
        check({tag, ".sram_addr"}, 32'(sram_addr), 32'(addr));
        check({tag, ".sram_ce_n"}, 32'(sram_ce_n), 32'(ce_n));
        check({tag, ".sram_oe_n"}, 32'(sram_oe_n), 32'(oe_n));
        check({tag, ".sram_we_n"}, 32'(sram_we_n), 32'(we_n));
        check({tag, ".avr_drive"}, 32'(dut.avr_drive), 32'(ad));
        check({tag, ".sram_drive"}, 32'(dut.sram_drive), 32'(sd));
        check({tag, ".both_driven"}, 32'(dut.avr_drive & dut.sram_drive), 32'd0);
        if (ad) check({tag, ".avr_data"}, 32'(avr_data), 32'(data));
        if (sd) check({tag, ".sram_data"}, 32'(sram_data), 32'(data));
    endtask

    // Behavioural model state
    int            m_mode;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_buf;

    task automatic model_edge();
        int nxt;
        nxt = m_mode;
        case (m_mode)
            M_READ: begin m_buf = tb_sram_val; if (avr_oe) nxt = M_IDLE; end
            M_WSET: begin m_buf = tb_avr_val;  nxt = avr_we ? M_IDLE : M_WRT; end
            M_WRT:  begin m_buf = tb_avr_val;  if (avr_we) nxt = M_IDLE; end
            default: begin
                if (avr_sreg_en && !avr_oe) nxt = M_READ;
                else if (avr_sreg_en && !avr_we) nxt = M_WSET;
            end
        endcase
        if (!avr_sreg_en) begin
            nxt = M_IDLE;
            m_addr = ((m_addr << 1) | AW'(avr_si)) & AMASK;
        end
        m_mode = nxt;
    endtask

    task automatic model_check(input string tag);
        check_all(tag, m_addr,
                  m_mode == M_IDLE, m_mode != M_READ, m_mode != M_WRT,
                  m_mode == M_READ, (m_mode == M_WSET) || (m_mode == M_WRT),
                  m_buf);
    endtask

    initial begin
        avr_reset = 1'b0; avr_si = 1'b0; avr_sreg_en = 1'b0;
        avr_oe = 1'b1; avr_we = 1'b1; avr_ce = 1'b1; avr_ctrl = 3'b000;
        tb_avr_val = 8'h00; tb_sram_val = 8'h00;

        // Directed vectors: address load, read, write, turnaround, priority, gating
        vecs[0]  = mk(0,1,1,1, 8'h00,8'h00, 21'h00001, 1,1,1,0,0, 8'h00);
        vecs[1]  = mk(0,0,1,1, 8'h00,8'h00, 21'h00002, 1,1,1,0,0, 8'h00);
        vecs[2]  = mk(0,0,1,1, 8'h00,8'h00, 21'h00004, 1,1,1,0,0, 8'h00);
        vecs[3]  = mk(0,1,1,1, 8'h00,8'h00, 21'h00009, 1,1,1,0,0, 8'h00);
        vecs[4]  = mk(0,1,1,1, 8'h00,8'h00, 21'h00013, 1,1,1,0,0, 8'h00);
        vecs[5]  = mk(0,0,1,1, 8'h00,8'h00, 21'h00026, 1,1,1,0,0, 8'h00);
        vecs[6]  = mk(0,0,1,1, 8'h00,8'h00, 21'h0004C, 1,1,1,0,0, 8'h00);
        vecs[7]  = mk(0,1,1,1, 8'h00,8'h00, 21'h00099, 1,1,1,0,0, 8'h00);
        vecs[8]  = mk(0,1,1,1, 8'h00,8'h00, 21'h00133, 1,1,1,0,0, 8'h00);
        vecs[9]  = mk(0,0,1,1, 8'h00,8'h00, 21'h00266, 1,1,1,0,0, 8'h00);
        vecs[10] = mk(0,0,1,1, 8'h00,8'h00, 21'h004CC, 1,1,1,0,0, 8'h00);
        vecs[11] = mk(0,1,1,1, 8'h00,8'h00, 21'h00999, 1,1,1,0,0, 8'h00);
        vecs[12] = mk(0,1,1,1, 8'h00,8'h00, 21'h01333, 1,1,1,0,0, 8'h00);
        vecs[13] = mk(0,1,1,1, 8'h00,8'h00, 21'h02667, 1,1,1,0,0, 8'h00);
        vecs[14] = mk(0,1,1,1, 8'h00,8'h00, 21'h04CCF, 1,1,1,0,0, 8'h00);
        vecs[15] = mk(1,0,1,1, 8'h00,8'h00, 21'h04CCF, 1,1,1,0,0, 8'h00);
        vecs[16] = mk(1,1,1,1, 8'h00,8'h00, 21'h04CCF, 1,1,1,0,0, 8'h00);
        vecs[17] = mk(1,0,0,1, 8'h00,8'hAA, 21'h04CCF, 0,0,1,1,0, 8'h00);
        vecs[18] = mk(1,0,0,1, 8'h00,8'hAA, 21'h04CCF, 0,0,1,1,0, 8'hAA);
        vecs[19] = mk(1,0,0,1, 8'h00,8'hBB, 21'h04CCF, 0,0,1,1,0, 8'hBB);
        vecs[20] = mk(1,0,1,1, 8'h00,8'hBB, 21'h04CCF, 1,1,1,0,0, 8'h00);
        vecs[21] = mk(1,0,1,0, 8'hEE,8'h00, 21'h04CCF, 0,1,1,0,1, 8'hBB);
        vecs[22] = mk(1,0,1,0, 8'hEE,8'h00, 21'h04CCF, 0,1,0,0,1, 8'hEE);
        vecs[23] = mk(1,0,1,0, 8'hEE,8'h00, 21'h04CCF, 0,1,0,0,1, 8'hEE);
        vecs[24] = mk(1,0,0,1, 8'hEE,8'h22, 21'h04CCF, 1,1,1,0,0, 8'h00);
        vecs[25] = mk(1,0,0,1, 8'hEE,8'h22, 21'h04CCF, 0,0,1,1,0, 8'hEE);
        vecs[26] = mk(1,0,0,1, 8'hEE,8'h22, 21'h04CCF, 0,0,1,1,0, 8'h22);
        vecs[27] = mk(1,0,1,1, 8'h00,8'h22, 21'h04CCF, 1,1,1,0,0, 8'h00);
        vecs[28] = mk(1,0,0,0, 8'h00,8'h5A, 21'h04CCF, 0,0,1,1,0, 8'h22);
        vecs[29] = mk(0,1,0,0, 8'h00,8'h5A, 21'h0999F, 1,1,1,0,0, 8'h00);
        vecs[30] = mk(1,0,1,1, 8'h00,8'h00, 21'h0999F, 1,1,1,0,0, 8'h00);

        // Power-on reset held across clocks
        repeat (2) @(posedge avr_clk);
        #1;
        $display("reset: held low over clocks");
        check_all("por", '0, 1, 1, 1, 0, 0, 8'h00);

        // Asynchronous reset in the middle of a read
        @(negedge avr_clk);
        avr_reset = 1'b1;
        avr_sreg_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            avr_si = 1'b1;
            @(posedge avr_clk); #1;
        end
        avr_sreg_en = 1'b1; avr_oe = 1'b0; tb_sram_val = 8'h3C;
        @(posedge avr_clk); #1;
        $display("pre-reset read: addr=0x%0h ce_n=%0b oe_n=%0b", sram_addr, sram_ce_n, sram_oe_n);
        check_all("mid_read", 21'h7, 0, 0, 1, 1, 0, 8'h00);
        #2;
        avr_reset = 1'b0;
        #1;
        $display("async reset mid-read: addr=0x%0h ce_n=%0b oe_n=%0b we_n=%0b", sram_addr, sram_ce_n, sram_oe_n, sram_we_n);
        check_all("async_rst", '0, 1, 1, 1, 0, 0, 8'h00);
        avr_oe = 1'b1; avr_sreg_en = 1'b0; avr_si = 1'b0;
        @(negedge avr_clk);
        avr_reset = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < NVEC; i++) begin
            avr_sreg_en = vecs[i].sreg_en;
            avr_si      = vecs[i].si;
            avr_oe      = vecs[i].oe;
            avr_we      = vecs[i].we;
            tb_avr_val  = vecs[i].avr_val;
            tb_sram_val = vecs[i].sram_val;
            @(posedge avr_clk); #1;
            $display("vec %0d: addr=0x%0h ce_n=%0b oe_n=%0b we_n=%0b avr=0x%0h sram=0x%0h",
                     i, sram_addr, sram_ce_n, sram_oe_n, sram_we_n, avr_data, sram_data);
            check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ce_n, vecs[i].oe_n,
                      vecs[i].we_n, vecs[i].avr_drv, vecs[i].sram_drv, vecs[i].data);
        end

        // Randomized cycles against the model, starting from the table's end state
        m_mode = M_IDLE; m_addr = 21'h0999F; m_buf = 8'h5A;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2;
                avr_reset = 1'b0;
                #1;
                m_mode = M_IDLE; m_addr = '0; m_buf = '0;
                $display("rnd %0d: async reset", i);
                model_check($sformatf("rnd%0d_rst", i));
                #1;
                avr_reset = 1'b1;
            end
            avr_sreg_en = ($urandom_range(0, 7) != 0);
            avr_si      = 1'($urandom_range(0, 1));
            avr_oe      = ($urandom_range(0, 3) != 0);
            avr_we      = ($urandom_range(0, 2) != 0);
            avr_ce      = 1'($urandom_range(0, 1));
            avr_ctrl    = 3'($urandom_range(0, 7));
            tb_avr_val  = 8'($urandom_range(0, 255));
            tb_sram_val = 8'($urandom_range(0, 255));
            @(posedge avr_clk); #1;
            model_edge();
            $display("rnd %0d: mode=%0d addr=0x%0h ce_n=%0b oe_n=%0b we_n=%0b buf=0x%0h",
                     i, m_mode, sram_addr, sram_ce_n, sram_oe_n, sram_we_n, m_buf);
            model_check($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avr_sram_bridge.md
Name: avr_sram_bridge

Overview:
- CPLD glue between an AVR microcontroller and an external 8-bit SRAM.
- The AVR serially loads an SRAM address into an internal shift register.
- It then performs byte reads (SRAM→AVR) and writes (AVR→SRAM) through a registered, bidirectional data buffer, sequenced by a small bus state machine.
- Top level of the CPLD design.

Parameters:
- ADDR_WIDTH, 21, SRAM address / shift register width.
- DATA_WIDTH, 8, data bus width.

Ports:
- avr_clk  in  1  system clock; all state changes on the rising edge.
- avr_reset  in  1  asynchronous, active-low reset.
- avr_si  in  1  serial address input.
- avr_sreg_en  in  1  0 = shift address in; 1 = hold address and enable bus accesses.
- avr_oe  in  1  active-low read request.
- avr_we  in  1  active-low write request.
- avr_ce  in  1  reserved, ignored.
- avr_ctrl  in  3  reserved, ignored.
- avr_data  inout  DATA_WIDTH  AVR data bus.
- sram_data  inout  DATA_WIDTH  SRAM data bus.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_ce_n  out  1  SRAM chip enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset (avr_reset=0, asynchronous):
  - shift register = 0, state = IDLE, buffer = 0.
  - sram_ce_n = sram_oe_n = sram_we_n = 1.
  - avr_data and sram_data tri-stated.
- Shift register:
  - While avr_sreg_en=0, on each rising edge: sreg <= {sreg[ADDR_WIDTH-2:0], avr_si}. MSB first; the oldest bit moves toward the MSB.
  - While avr_sreg_en=1: sreg holds.
  - sram_addr = sreg continuously (combinational).
- Bus FSM. States: IDLE, READ, WRITE_SETUP, WRITE.
- Forcing rule: while avr_sreg_en=0, the FSM is forced to IDLE on the next edge regardless of state.
- IDLE:
  - ce_n/oe_n/we_n = 1; both buses Z.
  - avr_sreg_en=1 and avr_oe=0 → READ.
  - Else avr_sreg_en=1 and avr_we=0 → WRITE_SETUP.
  - Read wins if both requests are low.
- READ:
  - sram_ce_n=0, sram_oe_n=0; sram_data Z.
  - Each edge: buffer <= sram_data.
  - avr_data driven with buffer, so data appears one clock after it is valid on sram_data.
  - avr_oe=1 → IDLE on the next edge; avr_data returns to Z once the FSM is in IDLE.
- WRITE_SETUP:
  - sram_ce_n=0, sram_we_n=1; avr_data Z.
  - buffer <= avr_data; sram_data driven with buffer.
  - Next state: WRITE, or IDLE if avr_we=1.
- WRITE:
  - sram_ce_n=0, sram_we_n=0; sram_data driven with buffer.
  - buffer <= avr_data each edge, so late AVR data is tracked.
  - avr_we=1 → IDLE; sram_we_n rises with the state change while data is still held from the buffer register.
- Mutual exclusion: never drive avr_data and sram_data in the same cycle.
- Read↔write turnaround always passes through IDLE (minimum one dead cycle).
- Reset mid-access: outputs go inactive immediately; buses released.

Decomposition:
- Shared package: state encoding (IDLE, READ, WRITE_SETUP, WRITE); ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-modules: addr_sreg (serial-in shift register) and bus_fsm (state machine + buffer + tri-state enables), instantiated by avr_sram_bridge.

Test Plan:
- Reset: avr_reset=0 mid-stream → sram_addr=0, ce_n/oe_n/we_n=1, both buses Z, without waiting for a clock.
- Address load: avr_sreg_en=0, shift 1,0,0,1,1,0,0,1,1,0,0,1,1,1,1 (15 clocks), then avr_sreg_en=1 → sram_addr=0x04CCF; value stable over further clocks.
- Read: avr_oe=0, SRAM drives 0xAA → sram_ce_n=0, sram_oe_n=0; avr_data=0xAA one clock later. SRAM changes to 0xBB → avr_data=0xBB one clock later.
- Write: avr_oe=1, avr_we=0, avr_data=0xEE → path IDLE→WRITE_SETUP→WRITE; sram_data=0xEE; sram_we_n=0 in WRITE; avr_data never driven by DUT.
- Turnaround: from WRITE set avr_we=1, avr_oe=0; SRAM drives 0x22 → one IDLE cycle with sram_we_n=1 and both buses Z, then READ with avr_data=0x22.
- Priority/gating:
  - avr_oe=0 and avr_we=0 simultaneously → READ.
  - avr_sreg_en=0 during READ → IDLE next edge, sreg shifts.
